// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: shared op codes, FSM states and latency for the
// iterative RV32M multiply/divide unit.
package muldiv_sequencer_pkg;

  // funct3 encodings of the M-extension instructions
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  // start-to-done cycles for a full-length operation (32 CALC + FIX + DONE)
  localparam int MULDIV_LATENCY = 34;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // rs1 is treated as two's complement for MULH, MULHSU, DIV and REM
  function automatic logic rs1_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as two's complement for MULH, DIV and REM
  function automatic logic rs2_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational radix-2 iteration. For multiply it is an
// add-then-shift-right on the {acc_hi, acc_lo} product register; for divide
// it is a shift-left, trial subtract and quotient-bit insert.
module muldiv_step
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc_hi,
  input  logic [XLEN-1:0] acc_lo,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] acc_hi_next,
  output logic [XLEN-1:0] acc_lo_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic          fits;

  // The remainder always stays below the divisor, so XLEN bits hold it; only
  // the shifted trial value needs the extra bit.
  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
    shifted = {acc_hi, acc_lo[XLEN-1]};
    fits    = shifted >= {1'b0, operand};
    if (is_div) begin
      acc_hi_next = fits ? (shifted[XLEN-1:0] - operand) : shifted[XLEN-1:0];
      acc_lo_next = {acc_lo[XLEN-2:0], fits};
    end else begin
      acc_hi_next = sum[XLEN:1];
      acc_lo_next = {sum[0], acc_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit. Latches magnitudes
// on start, runs 32 muldiv_step iterations, sign-corrects in FIX and pulses
// done. Divide-by-zero and signed overflow finish one cycle after start.
// Build option MULDIV_ZERO_SKIP_EN: also short-circuits multiplies by zero
// and divides whose dividend magnitude is below the divisor magnitude.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            CPU_CLK,
  input  logic            CPU_RST_N,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [2:0]        op_q;
  logic              neg1_q, neg2_q;
  logic [CNT_W-1:0]  count_q;
  logic [XLEN-1:0]   acc_hi_q, acc_lo_q, operand_q;
  logic [XLEN-1:0]   step_hi, step_lo;

  logic              sgn1, sgn2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              special;
  logic [XLEN-1:0]   special_value;
  logic              accept;

  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   quotient, remainder, fixed_value;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div      (op_q[2]),
    .acc_hi      (acc_hi_q),
    .acc_lo      (acc_lo_q),
    .operand     (operand_q),
    .acc_hi_next (step_hi),
    .acc_lo_next (step_lo)
  );

  // Operand signs and magnitudes as seen at the start edge
  always_comb begin
    sgn1 = rs1_signed(op) & operand1[XLEN-1];
    sgn2 = rs2_signed(op) & operand2[XLEN-1];
    mag1 = sgn1 ? (-operand1) : operand1;
    mag2 = sgn2 ? (-operand2) : operand2;
  end

  // Cases whose answer is known at the start edge and skip CALC/FIX
  always_comb begin
    special       = 1'b0;
    special_value = '0;
    if (op[2]) begin
      if (operand2 == '0) begin
        special       = 1'b1;
        special_value = op[1] ? operand1 : '1;
      end else if (((op == OP_DIV) || (op == OP_REM)) && (operand1 == SMIN) && (operand2 == '1)) begin
        special       = 1'b1;
        special_value = op[1] ? '0 : SMIN;
      end
`ifdef MULDIV_ZERO_SKIP_EN
      else if (mag1 < mag2) begin
        special       = 1'b1;
        special_value = op[1] ? operand1 : '0;
      end
`endif
    end
`ifdef MULDIV_ZERO_SKIP_EN
    else if ((operand1 == '0) || (operand2 == '0)) begin
      special       = 1'b1;
      special_value = '0;
    end
`endif
  end

  // Sign correction and word selection applied in FIX
  always_comb begin
    product = {acc_hi_q, acc_lo_q};
    if (neg1_q ^ neg2_q) begin
      product = -product;
    end
    quotient  = (neg1_q ^ neg2_q) ? (-acc_lo_q) : acc_lo_q;
    remainder = neg1_q ? (-acc_hi_q) : acc_hi_q;
    case (op_q)
      OP_MUL:                       fixed_value = product[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fixed_value = product[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fixed_value = quotient;
      default:                      fixed_value = remainder;
    endcase
  end

  // A start only counts when idle or finishing, and never against a flush
  always_comb begin
    accept = start && !flush && ((state_q == IDLE) || (state_q == DONE));
  end

  // State register
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and status outputs; flush overrides every transition
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = special ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (count_q == CNT_W'(XLEN-1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_d = special ? DONE : CALC;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
    end
  end

  // Datapath: latch on accept, iterate in CALC, write the result in FIX
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      op_q      <= '0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      count_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      operand_q <= '0;
      result    <= '0;
    end else if (accept) begin
      op_q     <= op;
      neg1_q   <= sgn1;
      neg2_q   <= sgn2;
      count_q  <= '0;
      acc_hi_q <= '0;
      if (op[2]) begin
        acc_lo_q  <= mag1;
        operand_q <= mag2;
      end else begin
        acc_lo_q  <= mag2;
        operand_q <= mag1;
      end
      if (special) begin
        result <= special_value;
      end
    end else if ((state_q == CALC) && !flush) begin
      acc_hi_q <= step_hi;
      acc_lo_q <= step_lo;
      count_q  <= count_q + 1'b1;
    end else if ((state_q == FIX) && !flush) begin
      result <= fixed_value;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized and directed bench for muldiv_sequencer
// with a cycle-level behavioural reference built from 64-bit arithmetic.
module tb_muldiv_sequencer;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST_N = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] operand1 = '0;
  logic [31:0] operand2 = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  // reference model state
  int          cyc = 0;
  bit          mValid = 1'b0;
  int          mDoneAt = 0;
  logic [31:0] mPend = '0;
  logic [31:0] mResult = '0;

  muldiv_sequencer #(.XLEN(32), .CNT_W(5)) dut (
    .CPU_CLK   (CPU_CLK),
    .CPU_RST_N (CPU_RST_N),
    .start     (start),
    .flush     (flush),
    .op        (op),
    .operand1  (operand1),
    .operand2  (operand2),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  // RISC-V M-extension result from plain 64-bit arithmetic
  function automatic logic [31:0] refResult(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Start-to-done cycles: 1 for the early-out cases, 34 otherwise
  function automatic int refLatency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bit          sdiv;
    logic [31:0] ma, mb;
    sdiv = (o == 3'd4) || (o == 3'd6);
    ma = (sdiv && a[31]) ? (~a + 32'd1) : a;
    mb = (sdiv && b[31]) ? (~b + 32'd1) : b;
    if (o >= 3'd4 && b == 32'd0) return 1;
    if (sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_ZERO_SKIP_EN
    if (o < 3'd4 && (a == 32'd0 || b == 32'd0)) return 1;
    if (o >= 3'd4 && ma < mb) return 1;
`endif
    if (ma == mb) return 34;
    return 34;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expected);
    checks++;
    if (got !== expected) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, expected);
    end
  endtask

  // Drive one start pulse and follow it to done, checking timing and value
  task automatic applyStimulus(input string name, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expRes, input int expLat,
                               input bit pinModel);
    int lat;
    int busyCnt;
    bit got;
    if (pinModel) checkOutput({name, "_model"}, refResult(o, a, b), expRes);
    start = 1'b1;
    op = o;
    operand1 = a;
    operand2 = b;
    lat = 0;
    busyCnt = 0;
    got = 1'b0;
    while (!got && lat < 60) begin
      @(negedge CPU_CLK);
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        op = 3'($urandom);
        operand1 = $urandom;
        operand2 = $urandom;
      end
      if (done) got = 1'b1;
      else if (busy) busyCnt++;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout got=no done expected=done within 60 cycles", name);
    end else begin
      checkOutput({name, "_latency"}, 32'(lat), 32'(expLat));
      checkOutput({name, "_busy_cycles"}, 32'(busyCnt), 32'(expLat - 1));
      checkOutput({name, "_result"}, result, expRes);
    end
  endtask

  // Reference model: tracks the outstanding op and the held result per cycle
  initial forever begin
    @(posedge CPU_CLK or negedge CPU_RST_N);
    if (!CPU_RST_N) begin
      mValid = 1'b0;
      mDoneAt = 0;
      mResult = '0;
    end else begin
      if (flush) begin
        mValid = 1'b0;
      end else if (start && (!mValid || mDoneAt <= cyc)) begin
        mValid = 1'b1;
        mDoneAt = cyc + refLatency(op, operand1, operand2);
        mPend = refResult(op, operand1, operand2);
      end
      cyc++;
      if (!flush && mValid && mDoneAt == cyc) mResult = mPend;
    end
  end

  // Every-cycle comparison of the DUT against the reference model
  initial forever begin
    @(negedge CPU_CLK);
    if (CPU_RST_N) begin
      checkOutput("cyc_busy", 32'(busy), 32'(mValid && cyc < mDoneAt));
      checkOutput("cyc_done", 32'(done), 32'(mValid && cyc == mDoneAt));
      checkOutput("cyc_result", result, mResult);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=no finish expected=finish before 2000000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneCnt;
    logic [2:0]  o;
    logic [31:0] a, b;

    repeat (3) @(negedge CPU_CLK);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", result, 32'd0);
    CPU_RST_N = 1'b1;
    repeat (2) @(negedge CPU_CLK);

    $display("[TB] directed operations");
    applyStimulus("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b1);
    @(negedge CPU_CLK);
    applyStimulus("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 1'b1);
    applyStimulus("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b1);
    applyStimulus("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
    applyStimulus("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1);
    applyStimulus("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b1);
    applyStimulus("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b1);
    applyStimulus("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b1);
    applyStimulus("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 34, 1'b1);
    applyStimulus("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 34, 1'b1);

    $display("[TB] flush and ignored start");
    @(negedge CPU_CLK);
    start = 1'b1; op = 3'd0; operand1 = 32'd3; operand2 = 32'd5;
    doneCnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CPU_CLK);
      if (done) doneCnt++;
      if (i == 1) start = 1'b0;
      if (i == 5) begin start = 1'b1; op = 3'd5; operand1 = 32'd5; operand2 = 32'd0; end
      if (i == 6) start = 1'b0;
      if (i == 10) flush = 1'b1;
    end
    @(negedge CPU_CLK);
    flush = 1'b0;
    checkOutput("flush_busy", 32'(busy), 32'd0);
    checkOutput("flush_result", result, 32'd2);
    repeat (40) begin
      @(negedge CPU_CLK);
      if (done) doneCnt++;
    end
    checkOutput("flush_done_count", 32'(doneCnt), 32'd0);

    $display("[TB] back-to-back");
    applyStimulus("b2b_first", 3'd5, 32'd9, 32'd3, 32'd3, 34, 1'b1);
    applyStimulus("b2b_second", 3'd5, 32'd9, 32'd3, 32'd3, 34, 1'b1);

    $display("[TB] reset mid-operation");
    @(negedge CPU_CLK);
    start = 1'b1; op = 3'd0; operand1 = 32'd3; operand2 = 32'd5;
    @(negedge CPU_CLK);
    start = 1'b0;
    repeat (19) @(negedge CPU_CLK);
    #2;
    CPU_RST_N = 1'b0;
    #1;
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkOutput("midreset_result", result, 32'd0);
    repeat (2) @(negedge CPU_CLK);
    CPU_RST_N = 1'b1;
    @(negedge CPU_CLK);

    $display("[TB] random operations");
    for (int i = 0; i < 120; i++) begin
      o = 3'($urandom_range(0, 7));
      a = pickOperand();
      b = pickOperand();
      if ($urandom_range(0, 1) == 0) @(negedge CPU_CLK);
      applyStimulus("rand", o, a, b, refResult(o, a, b), refLatency(o, a, b), 1'b0);
    end

    $display("[TB] random flushes");
    for (int i = 0; i < 15; i++) begin
      start = 1'b1;
      op = 3'($urandom_range(0, 7));
      operand1 = pickOperand();
      operand2 = pickOperand();
      @(negedge CPU_CLK);
      start = 1'b0;
      repeat ($urandom_range(0, 38)) @(negedge CPU_CLK);
      flush = 1'b1;
      @(negedge CPU_CLK);
      flush = 1'b0;
      repeat (2) @(negedge CPU_CLK);
    end

    repeat (3) @(negedge CPU_CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
